// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI arbiter that multiplexes one SPI master
// between the inertial-sensor and A2D requesters.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        BUSY,
        RESP
    } state_t;

    typedef enum logic {
        REQ_INERT = 1'b0,
        REQ_A2D   = 1'b1
    } req_id_t;

    localparam int unsigned TIMEOUT_CYC_DEF = 1024;
    localparam logic [15:0] ABORT_FILL      = 16'hFFFF;

    // Watchdog counter width: clog2 of the limit, never narrower than 10 bits.
    function automatic int unsigned cnt_width(input int unsigned cyc);
        return ($clog2(cyc) < 10) ? 10 : $clog2(cyc);
    endfunction

endpackage

// File: rtl/spi_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone request wins outright,
// a tie goes to the requester that was not granted last.
module rr_arb2
    import spi_arb_pkg::*;
(
    input  logic    req_inert,
    input  logic    req_a2d,
    input  req_id_t last_grant,
    output logic    gnt_vld,
    output req_id_t gnt_id
);

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        gnt_vld = req_inert | req_a2d;
        gnt_id  = REQ_INERT;
        if (req_inert && req_a2d) begin
            if (last_grant == REQ_INERT) begin
                gnt_id = REQ_A2D;
            end
        end else if (req_a2d) begin
            gnt_id = REQ_A2D;
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master between the inertial and A2D interfaces, one 16-bit
// transaction at a time. Optional BUSY watchdog enabled by SPI_ARB_TIMEOUT_EN.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_inert,
  input  logic [15:0] cmd_inert,
  input  logic        req_a2d,
  input  logic [15:0] cmd_a2d,
  output logic        ack_inert,
  output logic        ack_a2d,
  output logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] spi_rd,
  output logic        sel_a2d,
  output logic        timeout_err
);

  state_t      state, state_nxt;
  req_id_t     last_grant, last_grant_nxt;
  logic        gnt_vld;
  req_id_t     gnt_id;
  logic        wrt_nxt, ack_inert_nxt, ack_a2d_nxt, sel_a2d_nxt;
  logic [15:0] cmd_nxt, rd_data_nxt;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned      CNT_W    = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] to_cnt, to_cnt_nxt;
  logic             timeout_err_nxt;
`endif

  rr_arb2 u_rr_arb2 (
    .req_inert  (req_inert),
    .req_a2d    (req_a2d),
    .last_grant (last_grant),
    .gnt_vld    (gnt_vld),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    wrt_nxt        = 1'b0;
    ack_inert_nxt  = 1'b0;
    ack_a2d_nxt    = 1'b0;
    sel_a2d_nxt    = sel_a2d;
    cmd_nxt        = cmd;
    rd_data_nxt    = rd_data;
`ifdef SPI_ARB_TIMEOUT_EN
    to_cnt_nxt      = to_cnt;
    timeout_err_nxt = timeout_err;
`endif
    case (state)
      IDLE: begin
        // Requests are only looked at here; commands are frozen at grant.
        if (gnt_vld) begin
          sel_a2d_nxt = (gnt_id == REQ_A2D);
          cmd_nxt     = (gnt_id == REQ_A2D) ? cmd_a2d : cmd_inert;
          wrt_nxt     = 1'b1;
          state_nxt   = LAUNCH;
        end
      end
      LAUNCH: begin
        state_nxt = BUSY;
`ifdef SPI_ARB_TIMEOUT_EN
        to_cnt_nxt = '0;
`endif
      end
      BUSY: begin
`ifdef SPI_ARB_TIMEOUT_EN
        to_cnt_nxt = to_cnt + CNT_W'(1);
`endif
        if (done) begin
          rd_data_nxt   = spi_rd;
          ack_inert_nxt = ~sel_a2d;
          ack_a2d_nxt   = sel_a2d;
          state_nxt     = RESP;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        // A done landing on the final count still wins over the abort.
        else if (to_cnt == CNT_LAST) begin
          rd_data_nxt     = ABORT_FILL;
          timeout_err_nxt = 1'b1;
          ack_inert_nxt   = ~sel_a2d;
          ack_a2d_nxt     = sel_a2d;
          state_nxt       = RESP;
        end
`endif
      end
      RESP: begin
        last_grant_nxt = sel_a2d ? REQ_A2D : REQ_INERT;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= REQ_A2D;
      wrt        <= 1'b0;
      ack_inert  <= 1'b0;
      ack_a2d    <= 1'b0;
      sel_a2d    <= 1'b0;
      cmd        <= '0;
      rd_data    <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      wrt        <= wrt_nxt;
      ack_inert  <= ack_inert_nxt;
      ack_a2d    <= ack_a2d_nxt;
      sel_a2d    <= sel_a2d_nxt;
      cmd        <= cmd_nxt;
      rd_data    <= rd_data_nxt;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt      <= to_cnt_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed corner cases plus random
// traffic, checked by a monitor against a transaction-level arbitration model.
module tb_spi_arbiter;

  localparam int TO_CYC = 16;

  logic        clk, rst_n;
  logic        req_inert, req_a2d, ack_inert, ack_a2d;
  logic        wrt, done, sel_a2d, timeout_err;
  logic [15:0] cmd_inert, cmd_a2d, rd_data, cmd, spi_rd;

  typedef struct {
    int          lat;
    bit          hang;
    logic [15:0] data;
  } plan_t;

  plan_t       plan_q[$];
  logic [15:0] rd_q[$];
  bit          exp_order[$];

  int checks = 0, failures = 0;
  int cyc = 0, done_cyc = -100, ack_cyc = -100, stray_cnt = 0;
  int more_i = 0, more_a = 0;
  bit mon_busy = 0, model_last = 1, cur_id = 0;
  logic [15:0] cur_cmd = '0, last_rd = '0;
  logic prev_rst = 0, prev_ri = 0, prev_ra = 0;
  logic [15:0] prev_ci = '0, prev_ca = '0;

  spi_arbiter #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_inert   (req_inert),
    .cmd_inert   (cmd_inert),
    .req_a2d     (req_a2d),
    .cmd_a2d     (cmd_a2d),
    .ack_inert   (ack_inert),
    .ack_a2d     (ack_a2d),
    .rd_data     (rd_data),
    .wrt         (wrt),
    .cmd         (cmd),
    .done        (done),
    .spi_rd      (spi_rd),
    .sel_a2d     (sel_a2d),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      prev_rst = rst_n;
      prev_ri  = req_inert;
      prev_ra  = req_a2d;
      prev_ci  = cmd_inert;
      prev_ca  = cmd_a2d;
    end
  end

  // SPI master stand-in: answers each wrt per plan (or random latency/data).
  initial begin
    plan_t p;
    int    seen, w;
    bit    late;
    seen = 0;
    done = 0;
    spi_rd = '0;
    forever begin
      @(negedge clk);
      done = 0;
      if (stray_cnt != seen) begin
        seen   = stray_cnt;
        spi_rd = 16'($urandom);
        done   = 1;
      end else if (rst_n && wrt) begin
        w = cyc;
        if (plan_q.size() > 0) begin
          p = plan_q.pop_front();
        end else begin
          p.lat  = 1 + int'($urandom % 12);
          p.hang = 0;
          p.data = 16'($urandom);
        end
        if (p.hang) begin
`ifdef SPI_ARB_TIMEOUT_EN
          rd_q.push_back(16'hFFFF);
          done_cyc = w + TO_CYC;
`endif
        end else begin
          late = 0;
          repeat (p.lat) begin
            @(negedge clk);
            if (!rst_n) late = 1;
          end
          spi_rd = p.data;
          done   = 1;
          if (!late) begin
            rd_q.push_back(p.data);
            done_cyc = cyc;
          end
        end
      end
    end
  end

  // Monitor: arbitration, timing and data rules applied to sampled inputs.
  initial begin
    bit          w, exp_wrt, exp_ack, ack_any;
    logic [15:0] exp_rd;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_busy   = 0;
        model_last = 1;
        ack_cyc    = -100;
        last_rd    = '0;
        continue;
      end
      exp_wrt = !mon_busy && prev_rst && (cyc >= ack_cyc + 2) && (prev_ri || prev_ra);
      if (wrt || exp_wrt) check("grant_timing", wrt, exp_wrt);
      if (wrt && exp_wrt) begin
        w = (prev_ri && prev_ra) ? !model_last : prev_ra;
        if (exp_order.size() > 0) check("grant_order", w, exp_order.pop_front());
        cur_id  = w;
        cur_cmd = w ? prev_ca : prev_ci;
        check("grant_sel", sel_a2d, cur_id);
        check("grant_cmd", cmd, cur_cmd);
        mon_busy = 1;
      end else if (mon_busy) begin
        check("hold_sel_cmd", {sel_a2d, cmd}, {cur_id, cur_cmd});
      end
      exp_ack = mon_busy && (cyc == done_cyc + 1);
      ack_any = ack_inert | ack_a2d;
      if (ack_any || exp_ack) check("ack_timing", ack_any, exp_ack);
      if (ack_any && exp_ack) begin
        check("ack_id", {ack_a2d, ack_inert}, cur_id ? 2'b10 : 2'b01);
        check("rd_expected", rd_q.size(), 1);
        exp_rd = (rd_q.size() > 0) ? rd_q.pop_front() : 16'hxxxx;
        check("rd_data", rd_data, exp_rd);
        last_rd    = exp_rd;
        mon_busy   = 0;
        ack_cyc    = cyc;
        model_last = cur_id;
      end else begin
        check("rd_stable", rd_data, last_rd);
      end
    end
  end

  // One cycle of requester behaviour: a requester drops req on its ack
  // unless it has a follow-up transaction queued.
  task automatic tick();
    @(negedge clk);
    #1;
    if (ack_inert && req_inert) begin
      if (more_i > 0) begin
        more_i--;
        cmd_inert = 16'($urandom);
      end else begin
        req_inert = 0;
      end
    end
    if (ack_a2d && req_a2d) begin
      if (more_a > 0) begin
        more_a--;
        cmd_a2d = 16'($urandom);
      end else begin
        req_a2d = 0;
      end
    end
  endtask

  task automatic wait_wrt(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!wrt && n < budget);
    check("wrt_seen", wrt, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((req_inert || req_a2d || mon_busy) && n < budget) begin
      tick();
      n++;
    end
    check("drained", {req_inert, req_a2d, mon_busy}, 3'b000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 0;
    req_inert = 0;
    req_a2d = 0;
    more_i = 0;
    more_a = 0;
    #1;
    check("reset_ctrl", {wrt, ack_inert, ack_a2d, sel_a2d, timeout_err}, 5'b0);
    check("reset_cmd", cmd, 16'h0);
    check("reset_rd", rd_data, 16'h0);
    repeat (2) tick();
    rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    req_inert = 0;
    req_a2d = 0;
    cmd_inert = '0;
    cmd_a2d = '0;
    repeat (3) tick();
    check("por_ctrl", {wrt, ack_inert, ack_a2d, sel_a2d, timeout_err}, 5'b0);
    check("por_data", {cmd, rd_data}, 32'h0);
    rst_n = 1;
    repeat (2) tick();

    // Single inertial transaction, done 40 cycles after wrt.
    plan_q.push_back('{lat: 40, hang: 0, data: 16'h1234});
    exp_order.push_back(0);
    req_inert = 1;
    cmd_inert = 16'hA5A5;
    wait_idle(80);
    check("single_rd", rd_data, 16'h1234);

    // Stray done in IDLE: no ack, rd_data untouched.
    stray_cnt++;
    repeat (4) tick();
    check("stray_rd", rd_data, 16'h1234);

    // Tie straight after reset, both held for two transactions each.
    do_reset();
    repeat (2) tick();
    exp_order.push_back(0);
    exp_order.push_back(1);
    exp_order.push_back(0);
    exp_order.push_back(1);
    more_i = 1;
    more_a = 1;
    req_inert = 1;
    cmd_inert = 16'h1111;
    req_a2d = 1;
    cmd_a2d = 16'h2222;
    wait_idle(200);

    // Command change two cycles after wrt is ignored.
    plan_q.push_back('{lat: 10, hang: 0, data: 16'hBEEF});
    exp_order.push_back(1);
    req_a2d = 1;
    cmd_a2d = 16'h0C00;
    wait_wrt(10);
    repeat (2) tick();
    cmd_a2d = 16'h1000;
    repeat (3) tick();
    check("cmd_frozen", cmd, 16'h0C00);
    wait_idle(40);
    req_a2d = 0;

    // A request raised and dropped during BUSY is never served.
    plan_q.push_back('{lat: 20, hang: 0, data: 16'h0F0F});
    exp_order.push_back(0);
    req_inert = 1;
    cmd_inert = 16'h3333;
    wait_wrt(10);
    repeat (2) tick();
    req_a2d = 1;
    cmd_a2d = 16'h4444;
    repeat (3) tick();
    req_a2d = 0;
    wait_idle(60);
    repeat (5) tick();

    // The loser raising during a transaction is served at the next IDLE.
    plan_q.push_back('{lat: 12, hang: 0, data: 16'h5555});
    exp_order.push_back(1);
    exp_order.push_back(0);
    req_a2d = 1;
    cmd_a2d = 16'h6666;
    wait_wrt(10);
    repeat (3) tick();
    req_inert = 1;
    cmd_inert = 16'h7777;
    wait_idle(80);

    // Reset mid-transaction: late done ignored, next tie goes to inertial.
    plan_q.push_back('{lat: 30, hang: 0, data: 16'hDEAD});
    req_a2d = 1;
    cmd_a2d = 16'h8888;
    exp_order.push_back(1);
    wait_wrt(10);
    repeat (5) tick();
    do_reset();
    repeat (40) tick();
    check("late_done_ignored", rd_data, 16'h0);
    exp_order.push_back(0);
    exp_order.push_back(1);
    req_inert = 1;
    cmd_inert = 16'h9999;
    req_a2d = 1;
    cmd_a2d = 16'hAAAA;
    wait_idle(80);

    // Random traffic, including occasional drops before grant.
    repeat (800) begin
      tick();
      if (!req_inert && ($urandom % 5 == 0)) begin
        req_inert = 1;
        cmd_inert = 16'($urandom);
        more_i = int'($urandom % 2);
      end else if (req_inert && !mon_busy && ($urandom % 20 == 0)) begin
        req_inert = 0;
      end
      if (!req_a2d && ($urandom % 5 == 0)) begin
        req_a2d = 1;
        cmd_a2d = 16'($urandom);
        more_a = int'($urandom % 2);
      end else if (req_a2d && !mon_busy && ($urandom % 20 == 0)) begin
        req_a2d = 0;
      end
    end
    more_i = 0;
    more_a = 0;
    wait_idle(200);
    repeat (3) tick();

`ifdef SPI_ARB_TIMEOUT_EN
    // done on the final watchdog count wins.
    plan_q.push_back('{lat: TO_CYC, hang: 0, data: 16'h5A5A});
    req_a2d = 1;
    cmd_a2d = 16'h0101;
    wait_idle(60);
    check("race_no_err", timeout_err, 0);
    check("race_rd", rd_data, 16'h5A5A);
    // Withheld done: abort with fill word and sticky error.
    plan_q.push_back('{lat: 0, hang: 1, data: 16'h0});
    req_inert = 1;
    cmd_inert = 16'h0202;
    wait_idle(60);
    check("timeout_err_set", timeout_err, 1);
    check("timeout_rd", rd_data, 16'hFFFF);
    plan_q.push_back('{lat: 5, hang: 0, data: 16'h1357});
    req_a2d = 1;
    cmd_a2d = 16'h0303;
    wait_idle(40);
    check("timeout_err_sticky", timeout_err, 1);
    do_reset();
`else
    // Without the watchdog a withheld done leaves the block in BUSY.
    plan_q.push_back('{lat: 0, hang: 1, data: 16'h0});
    req_inert = 1;
    cmd_inert = 16'h0202;
    wait_wrt(10);
    repeat (40) tick();
    check("no_timeout_err", timeout_err, 0);
    check("still_waiting", mon_busy, 1);
    do_reset();
`endif
    repeat (3) tick();
    check("order_consumed", exp_order.size(), 0);
    check("rd_consumed", rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Shares a single SPI master between the inertial-sensor interface and the A2D interface in the Segway top level, so both peripherals sit on one SPI engine instead of two. The arbiter grants one 16-bit transaction at a time using two-way round-robin, launches it on the master and steers the slave select. It then returns the read word and a completion pulse to the winning requester.

## Interface
- TIMEOUT_CYC, 1024, cycles in BUSY without `done` before the transaction is aborted (only used with SPI_ARB_TIMEOUT_EN).
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req_inert  in  1  inertial requester wants one transaction; held high until ack_inert.
- cmd_inert  in  16  inertial command word, valid while req_inert is high.
- req_a2d  in  1  A2D requester wants one transaction; held high until ack_a2d.
- cmd_a2d  in  16  A2D command word, valid while req_a2d is high.
- ack_inert  out  1  one-cycle completion pulse to inertial; rd_data valid that cycle.
- ack_a2d  out  1  one-cycle completion pulse to A2D; rd_data valid that cycle.
- rd_data  out  16  registered read word from the last completed transaction.
- wrt  out  1  one-cycle start pulse to the SPI master.
- cmd  out  16  command to the SPI master; stable from wrt until done.
- done  in  1  SPI master completion pulse.
- spi_rd  in  16  SPI master read data; valid with done.
- sel_a2d  out  1  slave-select steering: 0 = inertial, 1 = A2D; stable for the whole transaction.
- timeout_err  out  1  sticky abort flag; cleared only by reset.

## Operation
- States are IDLE, LAUNCH, BUSY and RESP. All outputs are registered (Moore).
- **IDLE:**
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester not granted last.
  - On a grant, latch the winner's command into cmd, set sel_a2d to the winner and go to LAUNCH.
- **LAUNCH:** wrt=1 for exactly this cycle, then go to BUSY.
- **BUSY:** wait for done. On done, capture spi_rd into rd_data and go to RESP.
- **RESP:** pulse the winner's ack for exactly this cycle, record the winner as last_grant, then return to IDLE.
- **Command capture:** cmd_inert and cmd_a2d are sampled only at grant. Later changes are ignored.
- **Request dropped before grant:** the request is not served and nothing is issued.
- **Request dropped after grant:** the transaction still completes and the ack is still issued.
- **Requests outside IDLE:** requests are ignored in LAUNCH, BUSY and RESP. A request raised by the loser while a transaction runs is served at the next IDLE.
- **Stray done:** done outside BUSY is ignored. rd_data and ack are unaffected.
- **Requester contract:** a requester drops req on the edge where it sees ack. Both requests are therefore low in the following IDLE cycle unless a new transaction is wanted.
- **Fairness:** with both requests held continuously, grants alternate strictly, e.g. I, A, I, A.
- **Reset values:** state=IDLE, last_grant=A2D (so inertial wins the first tie), and wrt, cmd, sel_a2d, ack_inert, ack_a2d, rd_data and timeout_err all 0.
- **Reset mid-transaction:** the block returns to IDLE immediately with no ack. Any done arriving later is ignored.

## Timing
- A request sampled high in IDLE at edge k gives LAUNCH after edge k, so wrt is high during cycle k+1.
- cmd and sel_a2d are valid from cycle k+1 and do not change until RESP ends.
- done in cycle d gives rd_data and ack in cycle d+1.
- The earliest next wrt is cycle d+3, giving a minimum of 3 cycles of overhead per transaction beyond the SPI time.
- There is no combinational path from any input to any output.

## Configuration
- **SPI_ARB_TIMEOUT_EN defined:**
  - A 10-bit-minimum counter (width = clog2(TIMEOUT_CYC)) clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches TIMEOUT_CYC-1 without done, the block loads rd_data=16'hFFFF, sets timeout_err and goes to RESP, so the winner still receives its ack.
  - done arriving in the same cycle as the timeout wins: data is captured normally and no error is flagged.
- **SPI_ARB_TIMEOUT_EN undefined:** there is no counter, BUSY waits indefinitely and timeout_err is tied to 0.

## Structure
- Package spi_arb_pkg holds:
  - the state enum (IDLE, LAUNCH, BUSY, RESP);
  - the requester id (REQ_INERT=1'b0, REQ_A2D=1'b1);
  - the TIMEOUT_CYC default;
  - the abort fill value 16'hFFFF.
- One sub-module, rr_arb2: combinational two-way round-robin pick. Inputs are two requests and last_grant; outputs are a grant-valid flag and the winner id.
- The FSM, command and read-data registers, and the timeout counter all live in spi_arbiter.

## Test plan
- **Single inertial request:** req_inert=1, cmd_inert=16'hA5A5, done returned 40 cycles after wrt with spi_rd=16'h1234. Expect: wrt one cycle after the request, cmd=A5A5, sel_a2d=0, then ack_inert one cycle after done with rd_data=1234; ack_a2d stays 0.
- **Simultaneous requests after reset:** both raised together. Expect: inertial served first, then A2D. With both held for 4 transactions, grant order is I, A, I, A.
- **Command change after grant:** change cmd_a2d from 16'h0C00 to 16'h1000 two cycles after wrt. Expect: cmd stays 0C00 until ack_a2d.
- **Stray done:** pulse done while in IDLE. Expect: no ack and no change to rd_data.
- **Reset mid-transaction:** assert rst_n=0 during BUSY. Expect: all outputs 0 asynchronously; after release, a late done produces no ack, and the next tie goes to inertial.
- **Timeout (SPI_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=16):** withhold done. Expect: ack in the cycle after the 16th BUSY cycle, rd_data=16'hFFFF and timeout_err=1, held until reset. Without the macro, the same stimulus keeps the block in BUSY and timeout_err stays 0.
